// File: rtl/ws2812_pkg.sv
// Shared types, ns-to-cycle conversion and GRB reordering for the WS2812 chain driver.
// WS2812_BRIGHTNESS_EN adds the per-channel brightness scaling helpers.
package ws2812_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    LATCH
  } state_t;

  localparam int BITS_PER_PIXEL = 24;

  // 64-bit intermediate: 100 kHz-units times 280000 ns overflows 32 bits.
  function automatic int ns_to_cycles(input longint clock_hz, input longint ns);
    return int'((clock_hz / 1000) * ns / 1000000);
  endfunction

  function automatic pixel_t rgb_to_grb(input pixel_t rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] level);
    logic [15:0] product;
    product = 16'(c) * (16'(level) + 16'd1);
    return product[15:8];
  endfunction

  function automatic pixel_t scale_pixel(input pixel_t p, input logic [7:0] level);
    return {scale_channel(p[23:16], level), scale_channel(p[15:8], level),
            scale_channel(p[7:0], level)};
  endfunction
`endif

endpackage

// File: rtl/ws2812_chain_if.sv
// Host-side write/start port and LED-side outputs of ws2812_chain.
// WS2812_BRIGHTNESS_EN adds the i_Brightness input.
interface ws2812_chain_if #(
  parameter int NUM_LEDS = 8
);
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic          i_Wr_En;
  logic [AW-1:0] i_Wr_Addr;
  logic [23:0]   i_Wr_Data;
  logic          i_Start;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]    i_Brightness;
`endif
  logic          o_Led;
  logic          o_Ready;
  logic          o_Frame_Done;

  modport master (
    output i_Wr_En, i_Wr_Addr, i_Wr_Data, i_Start,
`ifdef WS2812_BRIGHTNESS_EN
    output i_Brightness,
`endif
    input  o_Led, o_Ready, o_Frame_Done
  );

  modport slave (
    input  i_Wr_En, i_Wr_Addr, i_Wr_Data, i_Start,
`ifdef WS2812_BRIGHTNESS_EN
    input  i_Brightness,
`endif
    output o_Led, o_Ready, o_Frame_Done
  );

endinterface

// File: rtl/ws2812_bit_encoder.sv
// One WS2812 bit: a strobe launches a HIGH phase of T0H/T1H cycles then LOW up to BIT_CYC;
// o_Bit_End marks the final cycle so the next strobe lands with no gap.
module ws2812_bit_encoder #(
  parameter int T0H_CYC = 40,
  parameter int T1H_CYC = 80,
  parameter int BIT_CYC = 125
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Bit,
  input  logic i_Strobe,
  output logic o_Led,
  output logic o_High_End,
  output logic o_Bit_End
);

  localparam int CW = $clog2(BIT_CYC);
  typedef logic [CW-1:0] count_t;
  localparam count_t BIT_LAST = count_t'(BIT_CYC - 1);
  localparam count_t T0H_LEN  = count_t'(T0H_CYC);
  localparam count_t T1H_LEN  = count_t'(T1H_CYC);

  logic   busy_q, busy_d;
  logic   bit_q, bit_d;
  logic   led_q;
  count_t count_q, count_d;

  function automatic count_t high_len(input logic b);
    return b ? T1H_LEN : T0H_LEN;
  endfunction

  assign o_Bit_End  = busy_q && (count_q == BIT_LAST);
  assign o_High_End = busy_q && (count_q == high_len(bit_q) - 1'b1);
  assign o_Led      = led_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    busy_d  = busy_q;
    bit_d   = bit_q;
    count_d = count_q;
    if (i_Strobe) begin
      busy_d  = 1'b1;
      bit_d   = i_Bit;
      count_d = '0;
    end else if (o_Bit_End) begin
      busy_d  = 1'b0;
      count_d = '0;
    end else if (busy_q) begin
      count_d = count_q + 1'b1;
    end
  end

  // The line level is computed from next-state values so o_Led is a flop, not a decode.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      busy_q  <= 1'b0;
      bit_q   <= 1'b0;
      count_q <= '0;
      led_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      bit_q   <= bit_d;
      count_q <= count_d;
      led_q   <= busy_d && (count_d < high_len(bit_d));
    end
  end

endmodule

// File: rtl/ws2812_chain.sv
// WS2812 string driver: NUM_LEDS-pixel buffer serialised in GRB order, then a latch gap.
// Define WS2812_BRIGHTNESS_EN to scale every channel by i_Brightness at pixel fetch.
module ws2812_chain
  import ws2812_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int NUM_LEDS        = 8,
  parameter int T0H_NS          = 400,
  parameter int T1H_NS          = 800,
  parameter int BIT_NS          = 1250,
  parameter int RESET_NS        = 280000
) (
  input  logic           i_Clock,
  input  logic           i_Reset,
  ws2812_chain_if.slave  bus
);

  localparam int T0H_CYC   = ns_to_cycles(CLOCK_FREQUENCY, T0H_NS);
  localparam int T1H_CYC   = ns_to_cycles(CLOCK_FREQUENCY, T1H_NS);
  localparam int BIT_CYC   = ns_to_cycles(CLOCK_FREQUENCY, BIT_NS);
  localparam int RESET_CYC = ns_to_cycles(CLOCK_FREQUENCY, RESET_NS);

  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LW = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
  localparam logic [AW:0]   NUM_LEDS_W = (AW + 1)'(NUM_LEDS);
  localparam logic [AW-1:0] LAST_PIX   = AW'(NUM_LEDS - 1);
  localparam logic [4:0]    LAST_BIT   = 5'(BITS_PER_PIXEL - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'((RESET_CYC > 0) ? RESET_CYC - 1 : 0);

  if (!(BIT_CYC > T1H_CYC && T1H_CYC > T0H_CYC && T0H_CYC >= 1 && NUM_LEDS >= 1)) begin : g_bad_cfg
    $error("ws2812_chain: need BIT_CYC > T1H_CYC > T0H_CYC >= 1 and NUM_LEDS >= 1");
  end

  state_t        state_q, state_d;
  logic          pending_q;
  logic [4:0]    bit_q;
  logic [AW-1:0] pix_q;
  logic [LW-1:0] latch_q;
  pixel_t        shift_q, shift_d;
  pixel_t        pix_buf [NUM_LEDS];
  logic          frame_done_q;
  logic          ready;
  logic          enc_strobe, enc_high_end, enc_bit_end, enc_led;
  logic          last_bit, last_pix;
  logic [AW-1:0] fetch_idx;
  pixel_t        fetch_grb;

  assign last_bit  = (bit_q == LAST_BIT);
  assign last_pix  = (pix_q == LAST_PIX);
  assign fetch_idx = (state_q == LOAD) ? '0 : pix_q + 1'b1;
`ifdef WS2812_BRIGHTNESS_EN
  assign fetch_grb = rgb_to_grb(scale_pixel(pix_buf[fetch_idx], bus.i_Brightness));
`else
  assign fetch_grb = rgb_to_grb(pix_buf[fetch_idx]);
`endif

  // NOTE: the buffer needs a reset because the host may start a frame before writing
  // every pixel; that rules out a RAM macro and keeps it as plain registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < NUM_LEDS; i++) pix_buf[i] <= '0;
    end else if (bus.i_Wr_En && ({1'b0, bus.i_Wr_Addr} < NUM_LEDS_W)) begin
      pix_buf[bus.i_Wr_Addr] <= bus.i_Wr_Data;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_Start || pending_q) state_d = LOAD;
      LOAD:    state_d = HIGH;
      HIGH:    if (enc_high_end) state_d = LOW;
      LOW:     if (enc_bit_end) state_d = (last_bit && last_pix) ? LATCH : HIGH;
      LATCH:   if (latch_q == LATCH_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enc_strobe = 1'b0;
    ready      = 1'b0;
    case (state_q)
      IDLE:    ready = !pending_q;
      LOAD:    enc_strobe = 1'b1;
      LOW:     enc_strobe = enc_bit_end && !(last_bit && last_pix);
      default: ;
    endcase
  end

  // The next bit is presented to the encoder from shift_d, so fetch and launch share an edge.
  always_comb begin
    shift_d = shift_q;
    if (state_q == LOAD) begin
      shift_d = fetch_grb;
    end else if (state_q == LOW && enc_bit_end) begin
      if (!last_bit)     shift_d = {shift_q[22:0], 1'b0};
      else if (!last_pix) shift_d = fetch_grb;
    end
  end

  // NOTE: non-blocking updates mean a fetch on the same edge as a write sees the old pixel.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      pending_q    <= 1'b0;
      bit_q        <= '0;
      pix_q        <= '0;
      latch_q      <= '0;
      shift_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      frame_done_q <= (state_q == LATCH) && (latch_q == LATCH_LAST);
      latch_q      <= (state_q == LATCH) ? latch_q + 1'b1 : '0;
      if (state_q == IDLE)   pending_q <= 1'b0;
      else if (bus.i_Start)  pending_q <= 1'b1;
      if (state_q == LOAD) begin
        bit_q <= '0;
        pix_q <= '0;
      end else if (state_q == LOW && enc_bit_end) begin
        if (last_bit) begin
          bit_q <= '0;
          if (!last_pix) pix_q <= pix_q + 1'b1;
        end else begin
          bit_q <= bit_q + 1'b1;
        end
      end
    end
  end

  ws2812_bit_encoder #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_encoder (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Bit      (shift_d[23]),
    .i_Strobe   (enc_strobe),
    .o_Led      (enc_led),
    .o_High_End (enc_high_end),
    .o_Bit_End  (enc_bit_end)
  );

  assign bus.o_Led        = enc_led;
  assign bus.o_Ready      = ready;
  assign bus.o_Frame_Done = frame_done_q;

endmodule

// File: tb/tb_ws2812_chain.sv
// Self-checking bench for ws2812_chain: two pixels, default bit timing, shortened latch gap.
module tb_ws2812_chain;

  localparam int N_LEDS    = 2;
  localparam int T0H       = 40;
  localparam int T1H       = 80;
  localparam int BITC      = 125;
  localparam int RESETC    = 1000;  // RESET_NS = 10000 at 100 MHz
  localparam int FRAME_LEN = 1 + N_LEDS * 24 * BITC + RESETC;

  typedef struct {
    logic [23:0] led0;
    logic [23:0] led1;
    logic [47:0] grb;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  ws2812_chain_if #(.NUM_LEDS(N_LEDS)) bus ();

  ws2812_chain #(
    .NUM_LEDS (N_LEDS),
    .RESET_NS (10000)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic write_pixel(input logic [0:0] addr, input logic [23:0] data);
    @(negedge clk);
    bus.i_Wr_En   = 1'b1;
    bus.i_Wr_Addr = addr;
    bus.i_Wr_Data = data;
    @(negedge clk);
    bus.i_Wr_En   = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.i_Start = 1'b1;
    @(negedge clk);
    bus.i_Start = 1'b0;
  endtask

  // Returns at the negedge after the start edge k (the LOAD cycle).
  task automatic start_frame(input string tag, output int k);
    pulse_start();
    k = cyc;
    check({tag, "_load_ready"}, bus.o_Ready, 0);
    check({tag, "_load_led"}, bus.o_Led, 0);
  endtask

  // From the LOAD cycle: measure every bit's high/low run, then the frame-done timing.
  task automatic measure_frame(input logic [47:0] exp, input string tag, input int k);
    int hi, lo, th, exp_lo;
    @(negedge clk);
    check({tag, "_first_high"}, bus.o_Led, 1);
    for (int b = 0; b < 48; b++) begin
      hi = 0;
      lo = 0;
      while (bus.o_Led === 1'b1 && hi < 200) begin
        hi++;
        @(negedge clk);
      end
      if (b == 47) begin
        while (bus.o_Led === 1'b0 && bus.o_Frame_Done !== 1'b1 && lo < RESETC + 200) begin
          lo++;
          @(negedge clk);
        end
      end else begin
        while (bus.o_Led === 1'b0 && lo < 200) begin
          lo++;
          @(negedge clk);
        end
      end
      th     = exp[47-b] ? T1H : T0H;
      exp_lo = BITC - th + ((b == 47) ? RESETC : 0);
      check($sformatf("%s_bit%0d_hi", tag, b), hi, th);
      check($sformatf("%s_bit%0d_lo", tag, b), lo, exp_lo);
    end
    check({tag, "_done"}, bus.o_Frame_Done, 1);
    check({tag, "_len"}, cyc - k, FRAME_LEN);
  endtask

  task automatic finish_idle(input string tag);
    check({tag, "_ready_at_done"}, bus.o_Ready, 1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, bus.o_Frame_Done, 0);
    check({tag, "_ready_after"}, bus.o_Ready, 1);
  endtask

  initial begin
    vec_t vecs [2];
    int   k;
    int   seen;

    vecs[0] = '{24'hFF0000, 24'h0000FF, 48'h00FF00_0000FF, "red_blue"};
    vecs[1] = '{24'h123456, 24'hABCDEF, 48'h341256_CDABEF, "mixed"};

    bus.i_Wr_En   = 1'b0;
    bus.i_Wr_Addr = '0;
    bus.i_Wr_Data = '0;
    bus.i_Start   = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
    bus.i_Brightness = 8'd255;
`endif

    repeat (3) @(negedge clk);
    check("reset_led", bus.o_Led, 0);
    check("reset_ready", bus.o_Ready, 1);
    check("reset_done", bus.o_Frame_Done, 0);
    rst = 1'b0;

    // Reset with a write pending clears the buffer and drops the write.
    write_pixel(1'b0, 24'hFF0000);
    @(negedge clk);
    bus.i_Wr_En   = 1'b1;
    bus.i_Wr_Addr = 1'b1;
    bus.i_Wr_Data = 24'hAAAAAA;
    rst = 1'b1;
    #1;
    check("wrrst_led", bus.o_Led, 0);
    check("wrrst_ready", bus.o_Ready, 1);
    check("wrrst_done", bus.o_Frame_Done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.i_Wr_En = 1'b0;
    start_frame("zeros", k);
    measure_frame(48'h0, "zeros", k);
    finish_idle("zeros");

    for (int i = 0; i < 2; i++) begin
      write_pixel(1'b0, vecs[i].led0);
      write_pixel(1'b1, vecs[i].led1);
      start_frame(vecs[i].name, k);
      measure_frame(vecs[i].grb, vecs[i].name, k);
      finish_idle(vecs[i].name);
    end

    // Two starts mid-frame collapse into one queued frame launched right after done.
    start_frame("pend1", k);
    fork
      measure_frame(48'h341256_CDABEF, "pend1", k);
      begin
        repeat (1000) @(negedge clk);
        pulse_start();
        repeat (1000) @(negedge clk);
        pulse_start();
      end
    join
    check("pend_ready_low", bus.o_Ready, 0);
    @(negedge clk);
    k = cyc;
    check("pend_load_led", bus.o_Led, 0);
    check("pend_load_done", bus.o_Frame_Done, 0);
    check("pend_load_ready", bus.o_Ready, 0);
    measure_frame(48'h341256_CDABEF, "pend2", k);
    finish_idle("pend2");
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.o_Led === 1'b1) seen++;
    end
    check("no_third_frame", seen, 0);

    // Writes during pixel 0: LED1 takes effect now, LED0 only next frame.
    start_frame("wr_mid", k);
    fork
      measure_frame(48'h341256_FF0000, "wr_mid", k);
      begin
        repeat (500) @(negedge clk);
        write_pixel(1'b0, 24'hC0FFEE);
        write_pixel(1'b1, 24'h00FF00);
      end
    join
    finish_idle("wr_mid");
    start_frame("wr_next", k);
    measure_frame(48'hFFC0EE_FF0000, "wr_next", k);
    finish_idle("wr_next");

`ifdef WS2812_BRIGHTNESS_EN
    write_pixel(1'b0, 24'h808080);
    write_pixel(1'b1, 24'h808080);
    bus.i_Brightness = 8'd127;
    start_frame("bright", k);
    measure_frame(48'h404040_404040, "bright", k);
    finish_idle("bright");
    bus.i_Brightness = 8'd255;
`endif

    // Reset mid HIGH phase: the line must drop before any clock edge.
    start_frame("rst_mid", k);
    @(negedge clk);
    check("rst_mid_high", bus.o_Led, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_led", bus.o_Led, 0);
    check("rst_mid_ready", bus.o_Ready, 1);
    check("rst_mid_done", bus.o_Frame_Done, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.o_Led === 1'b1) seen++;
    end
    check("rst_mid_stays_idle", seen, 0);
    check("rst_mid_ready_after", bus.o_Ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
